shared_adder61_scheduler: RTL and testbench

SHARED_ADDER61_SCHEDULER -- requirements
Module: shared_adder61_scheduler

---
 rtl/adder61_pkg.sv | 28 ++
 rtl/rr_arbiter4.sv | 28 ++
 rtl/shared_adder61_scheduler.sv | 106 ++++++++++
 tb/tb_shared_adder61_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder61_pkg.sv
// Shared constants, FSM encoding and helpers for the shared 61-bit adder scheduler.
// Holds requester count, operand/sum widths and the IDLE/HOLD state type.
package adder61_pkg;

    localparam int NREQ  = 4;
    localparam int PTR_W = 2;
    localparam int A_W   = 61;
    localparam int B_W   = 11;
    localparam int S_W   = 62;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: search starts at ptr and wraps.
// Ports: req (request vector), ptr (search start), grant (one-hot or zero).
module rr_arbiter4
    import adder61_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // 2-bit add wraps naturally, giving ptr, ptr+1, ... mod 4
            idx = ptr + PTR_W'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_adder61_scheduler.sv
// Time-shares one 61+11-bit adder among four requesters with round-robin
// arbitration and a single registered result slot (1 op/cycle when drained).
// Ports: clk, rst_n (async low); req_valid/req_a/req_b/req_ready per requester;
// res_valid/res_ready/res_sum/res_src result handshake; busy; op_count.
module shared_adder61_scheduler #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*61-1:0]  req_a,
    input  logic [NREQ*11-1:0]  req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [61:0]         res_sum,
    output logic [1:0]          res_src,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    import adder61_pkg::*;

    state_t           state_q, state_d;
    logic [S_W-1:0]   sum_q, sum_d;
    logic [PTR_W-1:0] src_q, src_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0]  grant;
    logic             load;
    logic             xfer;
    logic [PTR_W-1:0] win;
    logic [A_W-1:0]   a_sel;
    logic [B_W-1:0]   b_sel;
    logic [S_W-1:0]   sum_new;

    rr_arbiter4 u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign res_valid = (state_q == ST_HOLD);
    assign busy      = res_valid;
    assign res_sum   = sum_q;
    assign res_src   = src_q;
    assign op_count  = cnt_q;

    // Slot can take a new op when empty or being drained this cycle.
    assign load = (state_q == ST_IDLE) | (res_valid & res_ready);

    // rst_n gating keeps req_ready low for the whole reset window.
    assign req_ready = (load && rst_n) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign win       = oh_to_idx(grant);

    // Operand mux feeding the single shared adder.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[A_W*i +: A_W];
                b_sel = req_b[B_W*i +: B_W];
            end
        end
    end

    assign sum_new = {1'b0, a_sel} + S_W'(b_sel);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            state_d = ST_HOLD;
            sum_d   = sum_new;
            src_d   = win;
            ptr_d   = win + PTR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (res_valid && res_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shared_adder61_scheduler.sv
// Directed and random bench for shared_adder61_scheduler with a result scoreboard.
// Accepted requests push A+B/src; result handshakes pop and compare.
module tb_shared_adder61_scheduler;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req_valid;
    logic [243:0]   req_a;
    logic [43:0]    req_b;
    logic [3:0]     req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [61:0]    res_sum;
    logic [1:0]     res_src;
    logic           busy;
    logic [15:0]    op_count;

    typedef struct packed {
        logic [61:0] sum;
        logic [1:0]  src;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   waitc[4];

    shared_adder61_scheduler #(.NREQ(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_src   (res_src),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [60:0] a,
                          input logic [10:0] b);
        req_a[61*i +: 61] = a;
        req_b[11*i +: 11] = b;
    endtask

    // Called just after a falling edge with inputs driven; samples the
    // handshakes for this cycle, then advances to the next falling edge.
    task automatic tick();
        logic [3:0] acc;
        exp_t       e;
        exp_t       g;
        #1;
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        chk("busy_eq_valid", 64'(busy), 64'(res_valid));
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                g.sum = res_sum;
                g.src = res_src;
                chk("res_sum", 64'(g.sum), 64'(e.sum));
                chk("res_src", 64'(g.src), 64'(e.src));
            end
        end
        acc = req_valid & req_ready;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                e.sum = {1'b0, req_a[61*i +: 61]} + {51'd0, req_b[11*i +: 11]};
                e.src = 2'(i);
                sb.push_back(e);
                waitc[i] = 0;
            end else if (!req_valid[i]) begin
                waitc[i] = 0;
            end else if (acc != 4'd0) begin
                waitc[i] = waitc[i] + 1;
                if (waitc[i] > 3) begin
                    chk("starve", 64'(waitc[i]), 64'd3);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_wait();
        for (int i = 0; i < 4; i++) waitc[i] = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        clr_wait();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] vld;
        total     = 0;
        bad       = 0;
        clr_wait();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;

        // Reset state, requests pending
        #3;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_sum", 64'(res_sum), 64'd0);
        chk("rst_res_src", 64'(res_src), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op with max operands on requester 2
        req_valid = 4'b0100;
        set_op(2, 61'h1FFF_FFFF_FFFF_FFFF, 11'h7FF);
        res_ready = 1'b1;
        tick();
        req_valid = 4'b0000;
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_sum", 64'(res_sum), 64'h2000_0000_0000_07FE);
        chk("single_src", 64'(res_src), 64'd2);
        chk("single_count", 64'(op_count), 64'd1);
        tick();
        chk("single_drained", 64'(res_valid), 64'd0);

        // All four continuously valid from ptr=0
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 61'(100 * (i + 1)), 11'(i + 7));
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_valid", 64'(res_valid), 64'd1);
            chk("rr_src", 64'(res_src), 64'(i % 4));
        end
        req_valid = 4'h0;
        tick();
        chk("rr_drained", 64'(res_valid), 64'd0);

        // Backpressure: result 10+5 held for 5 cycles
        set_op(1, 61'd10, 11'd5);
        req_valid = 4'b0010;
        res_ready = 1'b1;
        tick();
        req_valid = 4'hF;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready_low", 64'(req_ready), 64'd0);
            chk("bp_sum", 64'(res_sum), 64'd15);
            chk("bp_valid", 64'(res_valid), 64'd1);
            #(-1 + 1);
            tick();
        end
        req_valid = 4'h0;
        res_ready = 1'b1;
        tick();
        chk("bp_drained", 64'(res_valid), 64'd0);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while holding a result
        set_op(3, 61'h123, 11'h45);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'h0;
        res_ready = 1'b0;
        chk("hold_before_rst", 64'(res_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_sum", 64'(res_sum), 64'd0);
        chk("mid_rst_count", 64'(op_count), 64'd0);
        sb.delete();
        clr_wait();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        tick();
        chk("post_rst_src", 64'(res_src), 64'd0);
        req_valid = 4'h0;
        tick();

        // Counter wrap after 65536 transfers
        do_reset();
        set_op(0, 61'd1, 11'd2);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        chk("cnt_max", 64'(op_count), 64'hFFFF);
        tick();
        chk("cnt_wrap", 64'(op_count), 64'd0);
        req_valid = 4'h0;
        tick();
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

        // Random traffic
        vld = 4'h0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!vld[i] || req_ready[i]) begin
                    vld[i] = $urandom_range(0, 1) == 1;
                    set_op(i, 61'({$urandom(), $urandom()}), 11'($urandom()));
                end else if ($urandom_range(0, 15) == 0) begin
                    vld[i] = 1'b0;
                end
            end
            req_valid = vld;
            res_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        req_valid = 4'h0;
        res_ready = 1'b1;
        tick();
        tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_idle", 64'(res_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
